// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory for the MIPS datapath: byte/half/word loads and stores,
// fault reporting, one-cycle registered response and an optional post-reset clear.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zeroing one word per cycle, requests refused
// ST_IDLE  | accepting one request per cycle
module data_memory_bytelane #(
    parameter int unsigned DEPTH_WORDS    = 256,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [1:0]  rsp_fault_code,
    output logic        init_done
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_cnt;
    logic            r_ready;
    logic            r_init_done;

    logic [31:0]     r_mem [0:DEPTH_WORDS-1];
    logic [31:0]     r_rd_word;

    logic            r_rsp_valid;
    logic            r_rsp_fault;
    logic [1:0]      r_rsp_code;
    logic            r_rd_load;
    logic [1:0]      r_rd_size;
    logic [1:0]      r_rd_lane;
    logic            r_rd_uns;

    logic            w_accept;
    logic [AW-1:0]   w_word_idx;
    logic [1:0]      w_lane;
    logic            w_oor;
    logic [1:0]      w_fault_code;
    logic            w_fault;
    logic [3:0]      w_st_be;
    logic [31:0]     w_st_data;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_idx;
    logic [3:0]      w_mem_be;
    logic [31:0]     w_mem_data;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_clr_cnt   <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == AW'(DEPTH_WORDS - 1)) begin
                        r_state     <= ST_IDLE;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    r_ready     <= 1'b1;
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_accept   = req_valid && r_ready;
    assign w_word_idx = req_addr[AW+1:2];
    assign w_lane     = req_addr[1:0];
    assign w_oor      = |req_addr[31:AW+2];

    // Bad size outranks range, which outranks alignment.
    always_comb begin
        w_fault_code = 2'd0;
        if (req_size == 2'b11) begin
            w_fault_code = 2'd3;
        end else if (w_oor) begin
            w_fault_code = 2'd2;
        end else if ((req_size == 2'b01 && w_lane[0]) ||
                     (req_size == 2'b10 && w_lane != 2'b00)) begin
            w_fault_code = 2'd1;
        end
    end

    assign w_fault = (w_fault_code != 2'd0);

    always_comb begin
        w_st_be   = 4'b0000;
        w_st_data = req_wdata;
        case (req_size)
            2'b00: begin
                w_st_be   = 4'b0001 << w_lane;
                w_st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_st_be   = 4'b1111;
                w_st_data = req_wdata;
            end
            default: begin
                w_st_be   = 4'b0000;
                w_st_data = req_wdata;
            end
        endcase
    end

    // The clear walk and request stores share the single write port; they never overlap.
    assign w_mem_we   = rst_n && ((r_state == ST_CLEAR) ||
                                  (w_accept && req_we && !w_fault));
    assign w_mem_idx  = (r_state == ST_CLEAR) ? r_clr_cnt : w_word_idx;
    assign w_mem_be   = (r_state == ST_CLEAR) ? 4'b1111 : w_st_be;
    assign w_mem_data = (r_state == ST_CLEAR) ? 32'h0 : w_st_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_mem_data[8*b +: 8];
                end
            end
        end
        r_rd_word <= r_mem[w_word_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_code  <= 2'd0;
            r_rd_load   <= 1'b0;
            r_rd_size   <= 2'd0;
            r_rd_lane   <= 2'd0;
            r_rd_uns    <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_fault <= w_accept && w_fault;
            r_rsp_code  <= w_accept ? w_fault_code : 2'd0;
            r_rd_load   <= w_accept && !req_we && !w_fault;
            r_rd_size   <= req_size;
            r_rd_lane   <= w_lane;
            r_rd_uns    <= req_unsigned;
        end
    end

    always_comb begin
        case (r_rd_lane)
            2'd0:    w_byte = r_rd_word[7:0];
            2'd1:    w_byte = r_rd_word[15:8];
            2'd2:    w_byte = r_rd_word[23:16];
            default: w_byte = r_rd_word[31:24];
        endcase
        w_half = r_rd_lane[1] ? r_rd_word[31:16] : r_rd_word[15:0];
    end

    always_comb begin
        w_rdata = 32'h0;
        if (r_rd_load) begin
            case (r_rd_size)
                2'b00:   w_rdata = r_rd_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                2'b01:   w_rdata = r_rd_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                2'b10:   w_rdata = r_rd_word;
                default: w_rdata = 32'h0;
            endcase
        end
    end

    assign req_ready      = r_ready;
    assign init_done      = r_init_done;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = w_rdata;
    assign rsp_fault      = r_rsp_fault;
    assign rsp_fault_code = r_rsp_code;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane: directed vector table, reset/clear sequences and
// random traffic against a byte-array reference model.
module tb_data_memory_bytelane;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_fault, init_done;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault_code;

    logic        rst_n_nc, req_valid_nc, req_we_nc, req_unsigned_nc;
    logic [1:0]  req_size_nc;
    logic [31:0] req_addr_nc, req_wdata_nc;
    logic        req_ready_nc, rsp_valid_nc, rsp_fault_nc, init_done_nc;
    logic [31:0] rsp_rdata_nc;
    logic [1:0]  rsp_fault_code_nc;

    data_memory_bytelane #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .rsp_fault_code(rsp_fault_code),
        .init_done(init_done)
    );

    data_memory_bytelane #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n_nc), .req_valid(req_valid_nc), .req_ready(req_ready_nc),
        .req_we(req_we_nc), .req_size(req_size_nc), .req_unsigned(req_unsigned_nc),
        .req_addr(req_addr_nc), .req_wdata(req_wdata_nc), .rsp_valid(rsp_valid_nc),
        .rsp_rdata(rsp_rdata_nc), .rsp_fault(rsp_fault_nc),
        .rsp_fault_code(rsp_fault_code_nc), .init_done(init_done_nc)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_bytes [0:4*DEPTH-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat little-endian byte array.
    function automatic void model_req(input logic we, input logic [1:0] size, input logic uns,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rd, output logic [1:0] code);
        int nb;
        logic [63:0] v;
        rd = 32'h0;
        if (size == 2'b11) code = 2'd3;
        else if (addr >= 32'(4*DEPTH)) code = 2'd2;
        else if ((size == 2'b01 && addr % 2 != 0) || (size == 2'b10 && addr % 4 != 0)) code = 2'd1;
        else code = 2'd0;
        if (code != 2'd0) return;
        nb = 1 << size;
        if (we) begin
            for (int i = 0; i < nb; i++) m_bytes[addr + i] = wdata[8*i +: 8];
        end else begin
            v = 64'h0;
            for (int i = 0; i < nb; i++) v = v | (64'(m_bytes[addr + i]) << (8*i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*nb));
            rd = v[31:0];
        end
    endfunction

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic drive_nc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_nc    = 1'b1;
        req_we_nc       = we;
        req_size_nc     = 2'b10;
        req_unsigned_nc = 1'b0;
        req_addr_nc     = addr;
        req_wdata_nc    = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] mrd;
        logic [1:0]  mcode;
        logic        was_valid;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        rst_n_nc = 1'b0; req_valid_nc = 1'b0; req_we_nc = 1'b0; req_size_nc = 2'b10;
        req_unsigned_nc = 1'b0; req_addr_nc = 32'h0; req_wdata_nc = 32'h0;
        for (int i = 0; i < 4*DEPTH; i++) m_bytes[i] = 8'h00;

        vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0,        32'h00000000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b1, 2'd2, 1'b0, 32'h08, 32'h11223344, 32'h00000000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd0, 1'b1, 32'h09, 32'h0,        32'h00000033, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b1, 2'd1, 1'b0, 32'h0A, 32'h00008000, 32'h00000000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0,        32'hFFFF8000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,        32'h00008000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b1, 2'd2, 1'b0, 32'h04, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 32'h05, 32'h000000AB, 32'h00000000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'hFFFFABFF, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        32'h00000000, 1'b1, 2'd1});
        vecs.push_back(vec_t'{1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 32'h00000000, 1'b1, 2'd2});
        vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd3, 1'b0, 32'h07, 32'h0,        32'h00000000, 1'b1, 2'd3});
        vecs.push_back(vec_t'{1'b1, 2'd3, 1'b0, 32'h00, 32'h55555555, 32'h00000000, 1'b1, 2'd3});
        vecs.push_back(vec_t'{1'b0, 2'd3, 1'b0, 32'h41, 32'h0,        32'h00000000, 1'b1, 2'd3});
        vecs.push_back(vec_t'{1'b0, 2'd1, 1'b0, 32'h41, 32'h0,        32'h00000000, 1'b1, 2'd2});
        vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 32'h03, 32'hFFFFFF80, 32'h00000000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b1, 2'd1, 1'b0, 32'h00, 32'hFFFF1234, 32'h00000000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        32'h80001234, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 32'h03, 32'h0,        32'hFFFFFF80, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd0, 1'b1, 32'h0B, 32'h0,        32'h00000080, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd1, 1'b0, 32'h08, 32'h0,        32'h00003344, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 32'h08, 32'h0,        32'h00000044, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b1, 2'd2, 1'b0, 32'h3C, 32'h01020304, 32'h00000000, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd0, 1'b1, 32'h3F, 32'h0,        32'h00000001, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd1, 1'b0, 32'h3E, 32'h0,        32'h00000102, 1'b0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h3F, 32'h0,        32'h00000000, 1'b1, 2'd1});

        // Reset values
        repeat (3) tick();
        check("rst ready", req_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rdata", rsp_rdata, 0);
        check("rst fault", rsp_fault, 0);
        check("rst code", rsp_fault_code, 0);
        check("rst init_done", init_done, 0);
        check("rst nc ready", req_ready_nc, 0);
        check("rst nc init_done", init_done_nc, 0);

        // Clear latency: ready/init_done rise after the DEPTH-th edge
        rst_n = 1'b1;
        rst_n_nc = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            check($sformatf("clr ready k%0d", k), req_ready, (k == DEPTH) ? 1 : 0);
            check($sformatf("clr init k%0d", k), init_done, (k == DEPTH) ? 1 : 0);
            if (k == 1) begin
                check("nc ready first edge", req_ready_nc, 1);
                check("nc init first edge", init_done_nc, 1);
            end
        end

        // Directed table, applied back to back
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            model_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                      mrd, mcode);
            tick();
            check($sformatf("vec%0d valid", i), rsp_valid, 1);
            check($sformatf("vec%0d rdata", i), rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d fault", i), rsp_fault, vecs[i].exp_fault);
            check($sformatf("vec%0d code", i), rsp_fault_code, vecs[i].exp_code);
        end
        req_valid = 1'b0;
        tick();
        check("idle after vecs valid", rsp_valid, 0);
        check("idle after vecs fault", rsp_fault, 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            was_valid = ($urandom_range(0, 3) != 0);
            if (was_valid) begin
                logic        we;
                logic [1:0]  sz;
                logic        un;
                logic [31:0] ad, wd;
                we = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                un = 1'($urandom_range(0, 1));
                ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 7));
                wd = $urandom;
                drive(we, sz, un, ad, wd);
                model_req(we, sz, un, ad, wd, mrd, mcode);
            end else begin
                req_valid = 1'b0;
                mrd = 32'h0;
                mcode = 2'd0;
            end
            tick();
            check($sformatf("rnd%0d valid", n), rsp_valid, was_valid);
            check($sformatf("rnd%0d rdata", n), rsp_rdata, mrd);
            check($sformatf("rnd%0d fault", n), rsp_fault, (mcode != 2'd0) ? 1 : 0);
            check($sformatf("rnd%0d code", n), rsp_fault_code, mcode);
        end
        req_valid = 1'b0;
        tick();

        // Reset pulsed during clear restarts the whole walk
        rst_n = 1'b0;
        tick();
        check("rst2 ready", req_ready, 0);
        check("rst2 init_done", init_done, 0);
        check("rst2 rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("clr5 ready", req_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            check($sformatf("reclr ready k%0d", k), req_ready, (k == DEPTH) ? 1 : 0);
        end
        for (int i = 0; i < 4*DEPTH; i++) m_bytes[i] = 8'h00;
        for (int w = 0; w < DEPTH; w++) begin
            drive(1'b0, 2'b10, 1'b0, 32'(4*w), 32'h0);
            model_req(1'b0, 2'b10, 1'b0, 32'(4*w), 32'h0, mrd, mcode);
            tick();
            check($sformatf("cleared w%0d", w), rsp_rdata, mrd);
        end
        req_valid = 1'b0;
        tick();

        // No-clear instance: contents survive reset, reset-edge store is dropped
        drive_nc(1'b1, 32'h10, 32'hCAFEF00D);
        tick();
        check("nc store valid", rsp_valid_nc, 1);
        drive_nc(1'b1, 32'h10, 32'h12345678);
        rst_n_nc = 1'b0;
        tick();
        check("nc rst rsp_valid", rsp_valid_nc, 0);
        check("nc rst ready", req_ready_nc, 0);
        req_valid_nc = 1'b0;
        rst_n_nc = 1'b1;
        tick();
        check("nc ready after rst", req_ready_nc, 1);
        drive_nc(1'b0, 32'h10, 32'h0);
        tick();
        check("nc load valid", rsp_valid_nc, 1);
        check("nc survive", rsp_rdata_nc, 32'hCAFEF00D);
        req_valid_nc = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_memory_bytelane.md
# data_memory_bytelane

Parametrised data memory for the single-cycle/multi-cycle MIPS datapath. It replaces the fixed 256×32 word-only store with:
- configurable depth;
- byte, half and word loads/stores, with sign or zero extension on loads;
- a valid/ready request port and fault reporting;
- an optional hardware clear sequence after reset.

It sits between the ALU address output and the write-back mux.

## Interface

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..65536
- CLEAR_ON_RESET, 1, 1 = zero all words after reset before accepting requests; 0 = contents untouched by reset

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block accepts request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for word and store
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response valid, one cycle per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  request rejected
- rsp_fault_code  out  2  0 none, 1 misaligned, 2 out of range, 3 bad size
- init_done  out  1  clear sequence finished (or skipped)

## Operation

- FSM states: CLEAR, IDLE.
  - rst_n low → CLEAR if CLEAR_ON_RESET = 1, else IDLE.
  - CLEAR: clear counter walks word 0..DEPTH_WORDS-1, writing 0 to one word per cycle. Moves to IDLE after the last word is written.
  - IDLE: req_ready = 1 every cycle; no other state.
- Accept: rising edge with req_valid && req_ready. Throughput is one request per cycle. There is no response backpressure; the consumer must take every response.
- Address split:
  - word index = req_addr[log2(DEPTH_WORDS)+1:2]
  - lane = req_addr[1:0]
  - Byte order is little-endian: lane 0 = bits [7:0].
  - Halfword lane 0 = [15:0], lane 2 = [31:16].
- Fault priority, highest first:
  - bad size (11)
  - out of range (req_addr ≥ 4×DEPTH_WORDS)
  - misaligned (half with addr[0] = 1; word with addr[1:0] ≠ 0)
  - A faulted store writes nothing. A faulted load returns rsp_rdata = 0.
- Store: only the addressed lanes are written; other bytes in the word are preserved.
- Load: the selected lane(s) are shifted to bit 0, then extended to 32 bits per req_unsigned.
- Ordering: a store accepted at edge N is visible to a load accepted at edge N+1 or later.

## Timing

- Reset values (while rst_n sampled low):
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0, rsp_fault_code = 0
  - init_done = 0, clear counter = 0
- Clear latency (CLEAR_ON_RESET = 1):
  - The first edge with rst_n high clears word 0; edge k clears word k-1.
  - After edge DEPTH_WORDS: state = IDLE, req_ready = 1, init_done = 1.
- CLEAR_ON_RESET = 0: req_ready = 1 and init_done = 1 after the first edge with rst_n high.
- Response latency is exactly 1 cycle. A request accepted at edge N has rsp_* valid after edge N and sampled at edge N+1.
  - rsp_valid drops after edge N+1 unless another request was accepted at edge N+1.
  - Registered read: load data comes from the memory array at the accept edge.
- rst_n low during CLEAR: counter returns to 0 and the full clear restarts on release.
- rst_n low during IDLE: the in-flight response is dropped (rsp_valid = 0). No write occurs on a reset edge.
- req_valid while req_ready = 0 is ignored. No request is queued.

## Test plan

- Reset release, DEPTH_WORDS = 16, CLEAR_ON_RESET = 1 → req_ready and init_done = 0 for 16 cycles, 1 from cycle 16; word load at 0x3C returns 0x00000000.
- Word store 0x11223344 @0x8, then load byte unsigned @0x9 → 0x00000033. Then load half signed @0xA (after storing 0x8000 there) → 0xFFFF8000; unsigned → 0x00008000.
- Store byte 0xAB @0x5 over word 0xFFFFFFFF @0x4 → word load @0x4 = 0xFFFFAB FF (0xFFFFABFF); back-to-back store/load shows new data with 1-cycle rsp latency and rsp_valid high both cycles.
- Fault checks, each with rsp_fault = 1:
  - word load @0x6 → fault_code 1
  - store @0x40 with DEPTH_WORDS = 16 → code 2, memory unchanged
  - size 11 @0x7 → code 3
- rst_n pulsed low at clear cycle 5 → clear restarts, req_ready rises 16 cycles after the second release. With CLEAR_ON_RESET = 0, data stored before reset survives reset.
